hazard_fwd_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage pipelined datapath.
- Generates the EX-stage and ID-stage forwarding selects.
- Generates the load-use and branch-dependency stall sequence, and the taken-branch/jump flush and PC-redirect strobe.
- Sits beside the datapath:
  - consumes its stage register-address and control taps;
  - drives its Stall, Flush, FwdPc, FwdRs, FwdRt, Fwd_IfId_Rs and Fwd_IfId_Rt inputs.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 29 ++
 rtl/hazard_fwd_ctrl_if.sv | 57 +++++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 30 +++
 rtl/hazard_fwd_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hz_pkg: shared constants for the hazard/forwarding controller.
//   FWD_* : 2-bit operand select encodings (11 is never driven).
//   hz_state_e : controller FSM states.
//   OP_* : opcodes the controller recognises.
//   src_match : non-zero destination matches one of two source addresses.
package hz_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  // $zero never carries a real dependency.
  function automatic logic src_match(input logic [4:0] dst,
                                     input logic [4:0] src_a,
                                     input logic [4:0] src_b);
    return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: datapath <-> hazard controller tap bundle.
//   Datapath-driven taps: OpCode, IfId_*, Ctrl_Branch, Br_Taken, IdEx_*,
//   ExMem_*, MemWb_*.
//   Controller-driven: FwdRs/FwdRt, Fwd_IfId_Rs/Rt, Stall, Flush, FwdPc,
//   Hz_Err, Stall_Cnt, Flush_Cnt.
//   master = datapath side, slave = controller side.
interface hazard_fwd_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [5:0]       OpCode;
  logic [4:0]       IfId_Rs;
  logic [4:0]       IfId_Rt;
  logic             Ctrl_Branch;
  logic             Br_Taken;
  logic [4:0]       IdEx_Rs;
  logic [4:0]       IdEx_Rt;
  logic [4:0]       IdEx_Rd;
  logic             IdEx_RegWrite;
  logic             IdEx_RegDst;
  logic             IdEx_MemRead;
  logic [4:0]       ExMem_Rd;
  logic             ExMem_Reg_Wr_Control;
  logic             ExMem_MemRead;
  logic [4:0]       MemWb_Rd;
  logic             MemWb_Reg_Wr_Control;

  logic [1:0]       FwdRs;
  logic [1:0]       FwdRt;
  logic [1:0]       Fwd_IfId_Rs;
  logic [1:0]       Fwd_IfId_Rt;
  logic             Stall;
  logic             Flush;
  logic             FwdPc;
  logic             Hz_Err;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;

  modport master (
    output OpCode, IfId_Rs, IfId_Rt, Ctrl_Branch, Br_Taken,
           IdEx_Rs, IdEx_Rt, IdEx_Rd, IdEx_RegWrite, IdEx_RegDst, IdEx_MemRead,
           ExMem_Rd, ExMem_Reg_Wr_Control, ExMem_MemRead,
           MemWb_Rd, MemWb_Reg_Wr_Control,
    input  FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt,
           Stall, Flush, FwdPc, Hz_Err, Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  OpCode, IfId_Rs, IfId_Rt, Ctrl_Branch, Br_Taken,
           IdEx_Rs, IdEx_Rt, IdEx_Rd, IdEx_RegWrite, IdEx_RegDst, IdEx_MemRead,
           ExMem_Rd, ExMem_Reg_Wr_Control, ExMem_MemRead,
           MemWb_Rd, MemWb_Reg_Wr_Control,
    output FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt,
           Stall, Flush, FwdPc, Hz_Err, Stall_Cnt, Flush_Cnt
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel: priority forwarding select for one source register address.
//   rst_i      : forces FWD_REG while high.
//   src_i      : source register address being resolved.
//   exmem_*_i  : EX/MEM write enable and destination (highest priority).
//   memwb_*_i  : MEM/WB write enable and destination.
//   sel_o      : FWD_MEM / FWD_WB / FWD_REG.
module fwd_sel
  import hz_pkg::*;
(
  input  logic       rst_i,
  input  logic [4:0] src_i,
  input  logic       exmem_wr_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_wr_i,
  input  logic [4:0] memwb_rd_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (!rst_i) begin
      if (exmem_wr_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (memwb_wr_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: pipeline hazard and forwarding controller.
//   CLK, RST : clock and synchronous active-high reset.
//   hz       : slave side of hazard_fwd_ctrl_if (datapath taps in,
//              forwarding selects / Stall / Flush / FwdPc / Hz_Err /
//              performance counters out).
//   STALL_MAX: consecutive Stall cycles that raise the sticky Hz_Err.
//   CNT_W    : performance counter width.
// Optional feature macro HZ_PERF_CNT_EN: when defined, Stall_Cnt and
// Flush_Cnt count Stall/Flush cycles (saturating); otherwise tied to 0.
module hazard_fwd_ctrl
  import hz_pkg::*;
#(
  parameter int STALL_MAX = 8,
  parameter int CNT_W     = 32
) (
  input logic              CLK,
  input logic              RST,
  hazard_fwd_ctrl_if.slave hz
);

  localparam int              WD_W    = $clog2(STALL_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_MAX - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(STALL_MAX);

  hz_state_e       state_q, state_d;
  logic [1:0]      rem_q, rem_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic            stall, flush, fwdpc;
  logic [4:0]      ex_dest;
  logic            lu, bex, bmem, hazard, need2, redirect, wd_trip;

  // Forwarding selects
  fwd_sel u_fwd_ex_rs (
    .rst_i(RST), .src_i(hz.IdEx_Rs),
    .exmem_wr_i(hz.ExMem_Reg_Wr_Control), .exmem_rd_i(hz.ExMem_Rd),
    .memwb_wr_i(hz.MemWb_Reg_Wr_Control), .memwb_rd_i(hz.MemWb_Rd),
    .sel_o(hz.FwdRs)
  );

  fwd_sel u_fwd_ex_rt (
    .rst_i(RST), .src_i(hz.IdEx_Rt),
    .exmem_wr_i(hz.ExMem_Reg_Wr_Control), .exmem_rd_i(hz.ExMem_Rd),
    .memwb_wr_i(hz.MemWb_Reg_Wr_Control), .memwb_rd_i(hz.MemWb_Rd),
    .sel_o(hz.FwdRt)
  );

  fwd_sel u_fwd_id_rs (
    .rst_i(RST), .src_i(hz.IfId_Rs),
    .exmem_wr_i(hz.ExMem_Reg_Wr_Control), .exmem_rd_i(hz.ExMem_Rd),
    .memwb_wr_i(hz.MemWb_Reg_Wr_Control), .memwb_rd_i(hz.MemWb_Rd),
    .sel_o(hz.Fwd_IfId_Rs)
  );

  fwd_sel u_fwd_id_rt (
    .rst_i(RST), .src_i(hz.IfId_Rt),
    .exmem_wr_i(hz.ExMem_Reg_Wr_Control), .exmem_rd_i(hz.ExMem_Rd),
    .memwb_wr_i(hz.MemWb_Reg_Wr_Control), .memwb_rd_i(hz.MemWb_Rd),
    .sel_o(hz.Fwd_IfId_Rt)
  );

  // Hazard terms
  always_comb begin
    ex_dest  = hz.IdEx_RegDst ? hz.IdEx_Rd : hz.IdEx_Rt;
    lu       = hz.IdEx_MemRead && src_match(hz.IdEx_Rt, hz.IfId_Rs, hz.IfId_Rt);
    bex      = hz.Ctrl_Branch && hz.IdEx_RegWrite && !hz.IdEx_MemRead &&
               src_match(ex_dest, hz.IfId_Rs, hz.IfId_Rt);
    bmem     = hz.Ctrl_Branch && hz.ExMem_MemRead &&
               src_match(hz.ExMem_Rd, hz.IfId_Rs, hz.IfId_Rt);
    hazard   = lu || bex || bmem;
    // A branch waiting on a load needs the value through MEM as well.
    need2    = lu && hz.Ctrl_Branch;
    redirect = (hz.Ctrl_Branch && hz.Br_Taken) || (hz.OpCode == OP_J);
  end

  // FSM next state and strobes
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    flush   = 1'b0;
    fwdpc   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hazard) begin
          stall = 1'b1;
          if (need2) begin
            state_d = STALL;
            rem_d   = 2'd1;
          end
        end else if (redirect) begin
          flush   = 1'b1;
          fwdpc   = 1'b1;
          state_d = FLUSH;
        end
      end
      STALL: begin
        stall = 1'b1;
        rem_d = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
        if (rem_d == 2'd0) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // IF/ID holds a bubble: nothing to detect or redirect.
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        rem_d   = 2'd0;
      end
    endcase
    if (RST) begin
      stall = 1'b0;
      flush = 1'b0;
      fwdpc = 1'b0;
    end
  end

  // Watchdog: the STALL_MAX-th consecutive stall cycle raises the error
  // in that same cycle; the register keeps it until reset.
  always_comb begin
    wd_trip = stall && (wd_q >= WD_LAST);
    err_d   = err_q || wd_trip;
    wd_d    = '0;
    if (stall) begin
      wd_d = (wd_q == WD_SAT) ? wd_q : wd_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      rem_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign hz.Stall  = stall;
  assign hz.Flush  = flush;
  assign hz.FwdPc  = fwdpc;
  assign hz.Hz_Err = err_q || wd_trip;

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.Stall_Cnt = stall_cnt_q;
  assign hz.Flush_Cnt = flush_cnt_q;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  assign hz.Stall_Cnt = CNT_ZERO;
  assign hz.Flush_Cnt = CNT_ZERO;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [4:0] ifrs, ifrt;
    logic       br, tk;
    logic [4:0] idrs, idrt, idrd;
    logic       idwr, iddst, idmr;
    logic [4:0] exrd;
    logic       exwr, exmr;
    logic [4:0] wbrd;
    logic       wbwr;
  } in_t;

  typedef struct packed {
    logic [1:0] rs, rt, irs, irt;
    logic       stall, flush, pc, err;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(.STALL_MAX(8), .CNT_W(CNT_W)) dut (
    .CLK(clk),
    .RST(rst),
    .hz (bus)
  );

  function automatic obs_t mk(input logic [1:0] rs, input logic [1:0] rt,
                              input logic [1:0] irs, input logic [1:0] irt,
                              input logic st, input logic fl,
                              input logic pc, input logic er);
    obs_t o;
    o.rs = rs; o.rt = rt; o.irs = irs; o.irt = irt;
    o.stall = st; o.flush = fl; o.pc = pc; o.err = er;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rs = bus.FwdRs; o.rt = bus.FwdRt;
    o.irs = bus.Fwd_IfId_Rs; o.irt = bus.Fwd_IfId_Rt;
    o.stall = bus.Stall; o.flush = bus.Flush; o.pc = bus.FwdPc; o.err = bus.Hz_Err;
    return o;
  endfunction

  // Drive one cycle of stimulus and record what the DUT must show for it.
  task automatic apply(input in_t v, input obs_t e);
    rst                      = v.rst;
    bus.OpCode               = v.op;
    bus.IfId_Rs              = v.ifrs;
    bus.IfId_Rt              = v.ifrt;
    bus.Ctrl_Branch          = v.br;
    bus.Br_Taken             = v.tk;
    bus.IdEx_Rs              = v.idrs;
    bus.IdEx_Rt              = v.idrt;
    bus.IdEx_Rd              = v.idrd;
    bus.IdEx_RegWrite        = v.idwr;
    bus.IdEx_RegDst          = v.iddst;
    bus.IdEx_MemRead         = v.idmr;
    bus.ExMem_Rd             = v.exrd;
    bus.ExMem_Reg_Wr_Control = v.exwr;
    bus.ExMem_MemRead        = v.exmr;
    bus.MemWb_Rd             = v.wbrd;
    bus.MemWb_Reg_Wr_Control = v.wbwr;
    sb.push_back(e);
  endtask

  function automatic in_t lu_in(input logic br);
    in_t v = '0;
    v.idmr = 1'b1; v.idrt = 5'd8; v.ifrs = 5'd8; v.br = br;
    return v;
  endfunction

  task automatic test_reset();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    v = lu_in(1'b1); v.rst = 1'b1; v.op = 6'h02; v.tk = 1'b1;
    v.exrd = 5'd5; v.exwr = 1'b1; v.idrs = 5'd5; v.ifrt = 5'd5;
    vs.push_back(v); es.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    checks++;
    if (bus.Stall_Cnt !== '0 || bus.Flush_Cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.Stall_Cnt, bus.Flush_Cnt);
    end
  endtask

  task automatic test_fwd();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    v = '0; v.exrd = 5'd5; v.exwr = 1'b1; v.wbrd = 5'd5; v.wbwr = 1'b1; v.idrs = 5'd5;
    vs.push_back(v); es.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    v.exwr = 1'b0;
    vs.push_back(v); es.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    v = '0; v.exwr = 1'b1; v.wbwr = 1'b1;
    vs.push_back(v); es.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    v = '0; v.idrs = 5'd7; v.idrt = 5'd5; v.exrd = 5'd7; v.exwr = 1'b1; v.wbrd = 5'd5; v.wbwr = 1'b1;
    vs.push_back(v); es.push_back(mk(2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0));
    v = '0; v.ifrs = 5'd3; v.ifrt = 5'd9; v.exrd = 5'd9; v.exwr = 1'b1; v.wbrd = 5'd3; v.wbwr = 1'b1;
    vs.push_back(v); es.push_back(mk(2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0));
    v = '0; v.ifrs = 5'd6; v.ifrt = 5'd6; v.exrd = 5'd6; v.exwr = 1'b1; v.wbrd = 5'd6; v.wbwr = 1'b1;
    vs.push_back(v); es.push_back(mk(2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fwd[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    vs.push_back(lu_in(1'b0)); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = '0; v.idrt = 5'd8; v.ifrs = 5'd8;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch_load();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    v = lu_in(1'b1); v.tk = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = '0; v.br = 1'b1; v.tk = 1'b1; v.ifrs = 5'd8;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = lu_in(1'b1); v.tk = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL branch_load[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_jump();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    v = '0; v.op = 6'h02;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0; v.br = 1'b1; v.tk = 1'b0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL jump[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch_dep();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    v = '0; v.br = 1'b1; v.idwr = 1'b1; v.iddst = 1'b1; v.idrd = 5'd4; v.ifrt = 5'd4;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = '0; v.br = 1'b1; v.exmr = 1'b1; v.exrd = 5'd4; v.ifrt = 5'd4;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = '0; v.br = 1'b1; v.tk = 1'b1; v.idwr = 1'b1; v.idrt = 5'd6; v.idrd = 5'd4; v.ifrs = 5'd6;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = '0; v.br = 1'b1; v.tk = 1'b1; v.ifrs = 5'd6;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0; v.br = 1'b1; v.idwr = 1'b1; v.iddst = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0; v.idwr = 1'b1; v.iddst = 1'b1; v.idrd = 5'd4; v.ifrt = 5'd4;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL branch_dep[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_watchdog();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    for (int c = 1; c <= 10; c++) begin
      vs.push_back(lu_in(1'b0)); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, (c >= 8)));
    end
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    v = lu_in(1'b0); v.rst = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(lu_in(1'b0)); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL watchdog[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    vs.push_back(lu_in(1'b1)); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    v = lu_in(1'b1); v.rst = 1'b1; v.exrd = 5'd5; v.exwr = 1'b1; v.idrs = 5'd5;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0; v.br = 1'b1; v.tk = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = '0; v.rst = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v = '0; v.op = 6'h02;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_perf_cnt();
    in_t vs[$]; obs_t es[$]; in_t v; obs_t got, exp;
    logic [CNT_W-1:0] exp_st, exp_fl;
    v = '0; v.rst = 1'b1;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      vs.push_back(lu_in(1'b0)); es.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    end
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    v.op = 6'h02;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    v = '0;
    vs.push_back(v); es.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vs.size(); i++) begin
      @(negedge clk); apply(vs[i], es[i]);
      #3; got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL perf_seq[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    @(negedge clk); #3;
`ifdef HZ_PERF_CNT_EN
    exp_st = 3; exp_fl = 2;
`else
    exp_st = 0; exp_fl = 0;
`endif
    checks++;
    if (bus.Stall_Cnt !== exp_st) begin
      errors++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.Stall_Cnt, exp_st);
    end
    checks++;
    if (bus.Flush_Cnt !== exp_fl) begin
      errors++; $display("FAIL flush_cnt got=%0d exp=%0d", bus.Flush_Cnt, exp_fl);
    end
  endtask

  initial begin
    in_t v;
    v = '0; v.rst = 1'b1;
    apply(v, mk(0, 0, 0, 0, 0, 0, 0, 0));
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    test_reset();
    test_fwd();
    test_load_use();
    test_branch_load();
    test_jump();
    test_branch_dep();
    test_watchdog();
    test_reset_mid();
    test_perf_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
